// File: rtl/accel_sched_pkg.sv
// Shared definitions for the accelerator scheduler.
// Holds the scheduler FSM state type and the operand/result widths that the
// scheduler, its arbiter and the accelerator command port must agree on.
package accel_sched_pkg;

    localparam int unsigned UI_W   = 2;
    localparam int unsigned VI_W   = 5;
    localparam int unsigned DATA_W = 21;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StFinish
    } sched_state_e;

endpackage

// File: rtl/accel_rr_pick2.sv
// Two-way round-robin pick.
// Ports:
//   req0, req1 : request levels from requester 0 / 1
//   last       : requester served most recently (0 or 1)
//   gnt        : one-hot grant, bit 0 = requester 0, bit 1 = requester 1
// A lone request always wins; on contention the requester not served last wins.
module accel_rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = {req1, req0};
        end
    end

endmodule

// File: rtl/accel_scheduler.sv
// Two-requester job scheduler for a single accelerator.
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   req0/1, ui0/1, vi0/1        : job requests and operands per requester
//   ack0/1                      : one-cycle grant pulse, operands latched at that edge
//   rvalid0/1, rdata            : result-word strobe per requester, shared result word
//   done0/1, err                : job-complete pulse, timeout-abort pulse
//   acc_wrStart, acc_ui, acc_vi : accelerator start command and operands
//   acc_done, acc_wrReq, acc_wrData : accelerator completion and result stream
// All outputs are registered. Flow: IDLE -> START (acc_wrStart held START_CYCLES
// cycles) -> BUSY (results forwarded with one cycle latency) -> FINISH -> IDLE,
// or BUSY -> IDLE with err once TIMEOUT BUSY cycles pass without acc_done.
module accel_scheduler
    import accel_sched_pkg::*;
#(
    parameter int unsigned START_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [UI_W-1:0]   ui0,
    input  logic [UI_W-1:0]   ui1,
    input  logic [VI_W-1:0]   vi0,
    input  logic [VI_W-1:0]   vi1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              acc_wrStart,
    output logic [UI_W-1:0]   acc_ui,
    output logic [VI_W-1:0]   acc_vi,
    input  logic              acc_done,
    input  logic              acc_wrReq,
    input  logic [DATA_W-1:0] acc_wrData
);

    localparam int unsigned SCNT_W = $clog2(START_CYCLES + 1);
    localparam int unsigned BCNT_W = $clog2(TIMEOUT + 1);

    sched_state_e      state_q;
    logic [SCNT_W-1:0] scnt_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic [BCNT_W-1:0] bcnt_d;
    logic              last_q;  // requester served last; 1 after reset so requester 0 leads
    logic              gnt_q;   // requester owning the current job
    logic [1:0]        pick;

    accel_rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .gnt  (pick)
    );

    always_comb begin
        bcnt_d = bcnt_q + BCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err         <= 1'b0;
            acc_wrStart <= 1'b0;
            acc_ui      <= '0;
            acc_vi      <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (pick != 2'b00) begin
                        ack0        <= pick[0];
                        ack1        <= pick[1];
                        gnt_q       <= pick[1];
                        acc_ui      <= pick[1] ? ui1 : ui0;
                        acc_vi      <= pick[1] ? vi1 : vi0;
                        acc_wrStart <= 1'b1;
                        // The ack cycle is the first of the START_CYCLES strobe cycles.
                        scnt_q      <= SCNT_W'(1);
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (scnt_q == SCNT_W'(START_CYCLES)) begin
                        acc_wrStart <= 1'b0;
                        scnt_q      <= '0;
                        bcnt_q      <= '0;
                        state_q     <= StBusy;
                    end else begin
                        scnt_q <= scnt_q + SCNT_W'(1);
                    end
                end
                StBusy: begin
                    if (acc_wrReq) begin
                        rdata   <= acc_wrData;
                        rvalid0 <= ~gnt_q;
                        rvalid1 <= gnt_q;
                    end
                    // acc_done wins over a timeout landing on the same cycle.
                    if (acc_done) begin
                        bcnt_q  <= '0;
                        state_q <= StFinish;
                    end else if (bcnt_d == BCNT_W'(TIMEOUT)) begin
                        err     <= 1'b1;
                        last_q  <= gnt_q;
                        bcnt_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        bcnt_q <= bcnt_d;
                    end
                end
                StFinish: begin
                    done0   <= ~gnt_q;
                    done1   <= gnt_q;
                    last_q  <= gnt_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/accel_scheduler.md
ACCEL_SCHEDULER -- requirements
Module: accel_scheduler

Interface
REQ-001 Parameter START_CYCLES, default 4, number of cycles acc_wrStart is held high per job.
REQ-002 Parameter TIMEOUT, default 4095, maximum BUSY cycles before a job is aborted.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 req0, req1  input  1 each  job request from requester 0 or 1, level.
REQ-006 ui0, ui1  input  2 each  u operand of the corresponding requester.
REQ-007 vi0, vi1  input  5 each  v operand of the corresponding requester.
REQ-008 ack0, ack1  output  1 each  one-cycle grant pulse; operands captured that cycle.
REQ-009 rvalid0, rvalid1  output  1 each  result-word strobe to the granted requester.
REQ-010 rdata  output  21  result word, shared by both requesters, qualified by rvalid0/rvalid1.
REQ-011 done0, done1  output  1 each  one-cycle job-complete pulse.
REQ-012 err  output  1  one-cycle pulse on timeout abort.
REQ-013 acc_wrStart  output  1; acc_ui  output  2; acc_vi  output  5  accelerator command.
REQ-014 acc_done  input  1; acc_wrReq  input  1; acc_wrData  input  21  accelerator status and results.

Function
REQ-015 FSM states: IDLE, START, BUSY, FINISH.
REQ-016 IDLE: if any req is high, the scheduler SHALL pick one winner, pulse its ack, latch its ui/vi into acc_ui/acc_vi, and go to START next cycle.
REQ-017 Arbitration: round-robin; the winner is the requester not served last; after reset requester 0 has priority.
REQ-018 If only one req is high, that requester wins regardless of pointer.
REQ-019 START: acc_wrStart high for exactly START_CYCLES cycles, acc_ui/acc_vi stable, then BUSY.
REQ-020 BUSY: each cycle acc_wrReq is high, rdata <= acc_wrData and the granted rvalid pulses one cycle later (1-cycle latency).
REQ-021 BUSY: acc_done high -> FINISH; if acc_wrReq is also high that cycle, the word is forwarded before done pulses.
REQ-022 FINISH: the granted done pulses for one cycle; pointer updates; return to IDLE.
REQ-023 Back-to-back: a requester holding req through FINISH is not re-granted if the other req is high in IDLE.
REQ-024 Timeout: a BUSY cycle counter SHALL reach TIMEOUT with no acc_done -> err pulse, no done pulse, return to IDLE, pointer advances.
REQ-025 acc_wrReq or acc_done in IDLE or START SHALL be ignored, with no rvalid/done pulse.
REQ-026 req dropping after ack SHALL NOT affect the running job; operands are not re-sampled.
REQ-027 Minimum job turnaround: ack to next possible ack = START_CYCLES + BUSY length + 2 cycles.

Reset
REQ-028 rst low at a rising edge SHALL force IDLE, pointer to requester 0, counters to 0, and all outputs to 0 (acc_wrStart, acc_ui, acc_vi, ack*, rvalid*, done*, err, rdata).
REQ-029 Reset mid-job SHALL drop acc_wrStart at that edge with no done or err pulse; the interrupted requester must re-request.

Structure
REQ-030 Shared package accel_sched_pkg SHALL hold the state enum and widths UI_W=2, VI_W=5, DATA_W=21.
REQ-031 Round-robin selection SHALL be one sub-module, accel_rr_pick2 (inputs: two reqs and last-served bit; outputs: one-hot grant).
REQ-032 Counters: a START counter of width clog2(START_CYCLES+1) and a BUSY counter of width clog2(TIMEOUT+1).

Verification
REQ-033 req0 with ui0=2'b10, vi0=5'b11000, model asserts done after 100 cycles -> ack0 then 4 cycles of acc_wrStart with acc_ui=2'b10, acc_vi=5'b11000, then done0 once.
REQ-034 req0 and req1 both high from reset -> grant order 0,1,0,1 across four jobs; ack never on both.
REQ-035 model issues 3 acc_wrReq words 0x1ABCD, 0x00001, 0x1FFFF, the last in the same cycle as acc_done -> three rvalid pulses with those rdata values, then done.
REQ-036 TIMEOUT=50, model never asserts done -> err at BUSY cycle 50, no done, and the next request is granted to the other requester.
REQ-037 rst low during START cycle 2 -> acc_wrStart low at the next edge, all outputs 0, and a new req1 is granted normally after release.
REQ-038 spurious acc_wrReq/acc_done in IDLE -> no rvalid, done, or err activity.
